// File: rtl/cu_pkg.sv
// Shared definitions for the banked control unit: FSM state encoding and a
// width helper that never returns zero, so single-entry ranges still get a 1-bit field.
package cu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } cu_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr_sweep_counter.sv
// Two-level word/bank sweep counter: address runs 0..DEPTH-1 and carries into the
// bank index 0..BANKS-1; 'last' flags the final word of the final bank.
module addr_sweep_counter import cu_pkg::*; #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BANKS  = 2,
  localparam int unsigned ADDR_W = clog2_min1(DEPTH),
  localparam int unsigned BANK_W = clog2_min1(BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BANK_W-1:0] bank_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  // NOTE: next-state values get a default first so no path through this block infers a latch.
  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    if (clr_i) begin
      addr_d = '0;
      bank_d = '0;
    end else if (adv_i) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
        bank_d = (bank_q == LAST_BANK) ? '0 : bank_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      bank_q <= '0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
    end
  end

  assign addr_o = addr_q;
  assign bank_o = bank_q;
  assign last_o = (addr_q == LAST_ADDR) && (bank_q == LAST_BANK);

endmodule

// File: rtl/banked_control_unit.sv
// Load -> compute -> drain sequencer over NUM_BANKS BRAM banks, with stall
// back-pressure, synchronous abort and continuous back-to-back runs.
module banked_control_unit import cu_pkg::*; #(
  parameter int unsigned BRAM_DEPTH = 4,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned PIPE_LAT   = 3,
  localparam int unsigned ADDR_W    = clog2_min1(BRAM_DEPTH),
  localparam int unsigned BANK_W    = clog2_min1(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cont_mode,
  input  logic              stall,
  input  logic              abort,
  output logic              busy,
  output logic              write_mode,
  output logic              enable_cu,
  output logic [BANK_W-1:0] bank_sel,
  output logic [ADDR_W-1:0] address,
  output logic              compute_ready
);

  localparam int unsigned        DRAIN_W    = clog2_min1(PIPE_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam bit                 NO_DRAIN   = (PIPE_LAT == 0);

  cu_state_e          state_q;
  logic               busy_q;
  logic               write_mode_q;
  logic               ready_q;
  logic [DRAIN_W-1:0] drain_q;

  logic sweeping;
  logic adv;
  logic sweep_last;
  logic sweep_done;
  logic run_done;
  logic sweep_clr;

  assign sweeping   = (state_q == S_LOAD) || (state_q == S_COMPUTE);
  assign adv        = sweeping && !stall && !abort;
  assign sweep_done = adv && sweep_last;
  // Counter sits at 0 outside the sweep so DRAIN/IDLE drive address/bank 0.
  assign sweep_clr  = abort || !sweeping || sweep_done;

  assign run_done = !abort &&
                    (((state_q == S_COMPUTE) && sweep_done && NO_DRAIN) ||
                     ((state_q == S_DRAIN) && (drain_q == DRAIN_LAST)));

  addr_sweep_counter #(
    .DEPTH (BRAM_DEPTH),
    .BANKS (NUM_BANKS)
  ) u_sweep (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (sweep_clr),
    .adv_i  (adv),
    .addr_o (address),
    .bank_o (bank_sel),
    .last_o (sweep_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      write_mode_q <= 1'b0;
      ready_q      <= 1'b0;
      drain_q      <= '0;
    end else begin
      ready_q <= run_done;
      if (abort) begin
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        write_mode_q <= 1'b0;
        drain_q      <= '0;
      end else if (run_done) begin
        state_q      <= cont_mode ? S_LOAD : S_IDLE;
        busy_q       <= cont_mode;
        write_mode_q <= cont_mode;
        drain_q      <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (enable) begin
              state_q      <= S_LOAD;
              busy_q       <= 1'b1;
              write_mode_q <= 1'b1;
            end
          end
          S_LOAD: begin
            if (sweep_done) begin
              state_q      <= S_COMPUTE;
              write_mode_q <= 1'b0;
            end
          end
          S_COMPUTE: begin
            if (sweep_done) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end
          end
          S_DRAIN: begin
            drain_q <= drain_q + 1'b1;
          end
          default: begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            write_mode_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign write_mode    = write_mode_q;
  assign compute_ready = ready_q;
  assign enable_cu     = (state_q == S_COMPUTE) && !stall;

endmodule
